// File: rtl/xs_stream_checker.sv
// Xorshift stream checker: compares each frame against the xs() chain seeded by
// word 0, counts mismatches, recovers the seed by inverting xs(word 0).
module xs_stream_checker #(
    parameter int FRAME_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] rand_num,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] seed_out,
    output logic [8:0]  err_cnt,
    output logic [7:0]  first_err_idx
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    // Recovery steps 1..11 do one operation each; 12 means finished, 0 means idle.
    localparam logic [3:0] REC_DONE = 4'd12;

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      exp_q, exp_d;
    logic [8:0]       err_q, err_d;
    logic [7:0]       first_q, first_d;
    logic             seen_q, seen_d;
    logic [3:0]       rec_step_q, rec_step_d;
    logic [31:0]      rec_x_q, rec_x_d;
    logic [31:0]      rec_y_q, rec_y_d;

    function automatic logic [31:0] xs(input logic [31:0] a);
        logic [31:0] b, c;
        b = a ^ (a << 13);
        c = b ^ (b >> 17);
        return c ^ (c << 5);
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        exp_d         = exp_q;
        err_d         = err_q;
        first_d       = first_q;
        seen_d        = seen_q;
        rec_step_d    = rec_step_q;
        rec_x_d       = rec_x_q;
        rec_y_d       = rec_y_q;
        busy          = 1'b0;
        out_valid     = 1'b0;
        seed_out      = 32'd0;
        err_cnt       = 9'd0;
        first_err_idx = 8'd0;

        // Undo the <<5, >>17 and <<13 xor-shifts in reverse order, runs free of in_valid.
        if (rec_step_q != 4'd0 && rec_step_q != REC_DONE) begin
            rec_step_d = rec_step_q + 4'd1;
            if (rec_step_q <= 4'd6)
                rec_x_d = rec_y_q ^ (rec_x_q << 5);
            else if (rec_step_q == 4'd7 || rec_step_q == 4'd9)
                rec_y_d = rec_x_q;
            else if (rec_step_q == 4'd8)
                rec_x_d = rec_y_q ^ (rec_x_q >> 17);
            else
                rec_x_d = rec_y_q ^ (rec_x_q << 13);
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d      = xs(rand_num);
                    idx_d      = IDX_W'(1);
                    err_d      = 9'd0;
                    first_d    = 8'd0;
                    seen_d     = 1'b0;
                    rec_x_d    = rand_num;
                    rec_y_d    = rand_num;
                    rec_step_d = 4'd1;
                    state_d    = (LAST_IDX == '0) ? REPORT : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (rand_num != exp_q) begin
                        err_d = err_q + 9'd1;
                        if (!seen_q) begin
                            first_d = 8'(idx_q);
                            seen_d  = 1'b1;
                        end
                    end
                    // Advance from the expected value so one bad word costs one error.
                    exp_d = xs(exp_q);
                    if (idx_q == LAST_IDX)
                        state_d = REPORT;
                    else
                        idx_d = idx_q + IDX_W'(1);
                end
            end
            REPORT: begin
                busy          = 1'b1;
                out_valid     = 1'b1;
                seed_out      = rec_x_q;
                err_cnt       = err_q;
                first_err_idx = first_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            exp_q      <= 32'd0;
            err_q      <= 9'd0;
            first_q    <= 8'd0;
            seen_q     <= 1'b0;
            rec_step_q <= 4'd0;
            rec_x_q    <= 32'd0;
            rec_y_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
            first_q    <= first_d;
            seen_q     <= seen_d;
            rec_step_q <= rec_step_d;
            rec_x_q    <= rec_x_d;
            rec_y_q    <= rec_y_d;
        end
    end

endmodule

// File: tb/tb_xs_stream_checker.sv
// Bench for xs_stream_checker: directed frames with literal expectations plus
// randomized frames, all checked every cycle against a frame-level model.
module tb_xs_stream_checker;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] rand_num;
    logic        busy;
    logic        out_valid;
    logic [31:0] seed_out;
    logic [8:0]  err_cnt;
    logic [7:0]  first_err_idx;

    xs_stream_checker #(.FRAME_LEN(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .rand_num     (rand_num),
        .busy         (busy),
        .out_valid    (out_valid),
        .seed_out     (seed_out),
        .err_cnt      (err_cnt),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 1'b0;
    logic [31:0] seed_of [logic [31:0]];
    logic [31:0] q_words [$];
    logic [31:0] frame [N];
    bit          m_rep = 1'b0;
    logic [31:0] m_seed = 32'd0;
    logic [8:0]  m_err = 9'd0;
    logic [7:0]  m_first = 8'd0;

    function automatic logic [31:0] xs(input logic [31:0] a);
        logic [31:0] b, c;
        b = a ^ (a << 13);
        c = b ^ (b >> 17);
        return c ^ (c << 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h want 0x%08h", name, $time, act, exp);
        end
    endtask

    // Model: a frame is the next N accepted words; its report is due the cycle after.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_rep});
            check("busy", {31'd0, busy}, {31'd0, m_rep});
            check("seed_out", seed_out, m_rep ? m_seed : 32'd0);
            check("err_cnt", {23'd0, err_cnt}, m_rep ? {23'd0, m_err} : 32'd0);
            check("first_err_idx", {24'd0, first_err_idx}, m_rep ? {24'd0, m_first} : 32'd0);
        end
        if (rst) begin
            q_words.delete();
            m_rep = 1'b0;
        end else if (m_rep) begin
            m_rep = 1'b0;
        end else if (in_valid) begin
            q_words.push_back(rand_num);
            if (q_words.size() == N) begin
                logic [31:0] e;
                int errs;
                int first;
                e = q_words[0];
                errs = 0;
                first = 0;
                for (int i = 1; i < N; i++) begin
                    e = xs(e);
                    if (q_words[i] != e) begin
                        errs++;
                        if (errs == 1) first = i;
                    end
                end
                m_seed  = seed_of.exists(q_words[0]) ? seed_of[q_words[0]] : 32'hBAD0BAD0;
                m_err   = 9'(errs);
                m_first = 8'(first);
                m_rep   = 1'b1;
                q_words.delete();
            end
        end
    end

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        rand_num = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rand_num = $urandom;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            rand_num = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen(input logic [31:0] s);
        frame[0] = xs(s);
        seed_of[frame[0]] = s;
        for (int i = 1; i < N; i++) frame[i] = xs(frame[i-1]);
    endtask

    task automatic send_frame(input int maxgap);
        for (int i = 0; i < N; i++) begin
            if (i > 0 && maxgap > 0) gap($urandom_range(0, maxgap));
            send(frame[i]);
        end
    endtask

    // Called right after the last word's edge, i.e. during the report cycle.
    task automatic expect_report(input string tag, input logic [31:0] s,
                                 input logic [8:0] e, input logic [7:0] f);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".seed"}, seed_out, s);
        check({tag, ".err"}, {23'd0, err_cnt}, {23'd0, e});
        check({tag, ".first"}, {24'd0, first_err_idx}, {24'd0, f});
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        rand_num = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.seed", seed_out, 32'd0);
        check("rst.err", {23'd0, err_cnt}, 32'd0);
        gap(3);

        // Clean seed-1 frame.
        gen(32'd1);
        check("xs(1)", frame[0], 32'h00042021);
        send_frame(0);
        expect_report("clean", 32'd1, 9'd0, 8'd0);
        gap(2);

        // Single flipped bit at word 17.
        gen(32'd1);
        frame[17] = frame[17] ^ 32'h1;
        send_frame(0);
        expect_report("flip17", 32'd1, 9'd1, 8'd17);
        gap(1);

        // Gapped stream with two corruptions.
        gen(32'hDEADBEEF);
        frame[3]   = frame[3] ^ 32'h0000_0100;
        frame[200] = frame[200] ^ 32'h8000_0000;
        send_frame(5);
        expect_report("gaps", 32'hDEADBEEF, 9'd2, 8'd3);
        gap(2);

        // Every word after word 0 wrong.
        gen(32'd7);
        for (int i = 1; i < N; i++) frame[i] = 32'd0;
        send_frame(0);
        expect_report("allbad", 32'd7, 9'd255, 8'd1);

        // Word offered in the report cycle is dropped; frame 2 follows.
        send(32'h1234_5678);
        gen(32'h0000_0042);
        frame[9] = ~frame[9];
        send_frame(0);
        expect_report("b2b", 32'h0000_0042, 9'd1, 8'd9);
        gap(2);

        // Reset at word 100 aborts the frame silently.
        gen(32'd9);
        for (int i = 0; i < 100; i++) send(frame[i]);
        rst = 1'b1;
        in_valid = 1'b1;
        rand_num = frame[100];
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        gap(20);
        gen(32'd5);
        send_frame(0);
        expect_report("after_rst", 32'd5, 9'd0, 8'd0);
        gap(2);

        // Random frames, checked by the model alone.
        for (int f = 0; f < 4; f++) begin
            gen($urandom);
            for (int i = 1; i < N; i++)
                if ($urandom_range(0, 63) == 0) frame[i] = frame[i] ^ ($urandom | 32'h1);
            send_frame(3);
            if ($urandom_range(0, 1) == 1) send($urandom);
            else gap($urandom_range(0, 4));
        end
        gap(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
